// File: rtl/imem_rw.sv
`default_nettype none
// ============================================================================
//  Module   : imem_rw
//  Purpose  : Writable instruction memory with registered fetch address,
//             byte-enabled write port and an optional post-reset NOP sweep.
//  Revision : 1.0
// ============================================================================
module imem_rw #(
    parameter int              ADDR_W         = 30,
    parameter int              DEPTH_LOG2     = 10,
    parameter int              DATA_W         = 32,
    parameter logic [DATA_W-1:0] NOP          = '0,
    parameter bit              CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   inst,
    output logic                inst_valid,
    output logic                oor,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic                wr_ready,
    output logic                wr_err,
    output logic                busy
);

    localparam int c_DEPTH = 2 ** DEPTH_LOG2;
    localparam int c_BYTES = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t c_RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    logic [DATA_W-1:0]     mem [c_DEPTH];

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic                  wr_err_q, wr_err_d;

    logic                  w_rd_oor;
    logic                  w_wr_oor;

    // Range checks look only at the bits above the array index, so no
    // upper address bits are ever dropped.
    generate
        if (ADDR_W > DEPTH_LOG2) begin : g_oor_cmp
            assign w_rd_oor = |addr_q[ADDR_W-1:DEPTH_LOG2];
            assign w_wr_oor = |wr_addr[ADDR_W-1:DEPTH_LOG2];
        end else begin : g_oor_none
            assign w_rd_oor = 1'b0;
            assign w_wr_oor = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_RST_STATE;
            clr_ptr_q <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            wr_err_q  <= wr_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        wr_err_d  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (&clr_ptr_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fetch_en) begin
                    addr_d  = addr;
                    valid_d = 1'b1;
                end
                wr_err_d = wr_en & w_wr_oor;
            end
            default: state_d = c_RST_STATE;
        endcase
    end

    // Storage has no reset; the clear sweep is the only way to initialise it.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_ptr_q] <= NOP;
        end else if (wr_en && !w_wr_oor) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr[DEPTH_LOG2-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign inst       = (valid_q && !w_rd_oor) ? mem[addr_q[DEPTH_LOG2-1:0]] : NOP;
    assign inst_valid = valid_q;
    assign oor        = valid_q & w_rd_oor;
    assign wr_err     = wr_err_q;
    assign busy       = (state_q == ST_CLEAR);
    assign wr_ready   = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_imem_rw.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_rw
//  Purpose  : Self-checking bench for imem_rw (16-word, clear-on-reset build).
//  Revision : 1.0
// ============================================================================
module tb_imem_rw;

    localparam int          c_AW  = 30;
    localparam logic [31:0] c_NOP = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              fetch_en = 1'b0;
    logic [c_AW-1:0]   addr = '0;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              oor;
    logic              wr_en = 1'b0;
    logic [c_AW-1:0]   wr_addr = '0;
    logic [31:0]       wr_data = '0;
    logic [3:0]        wr_be = '0;
    logic              wr_ready;
    logic              wr_err;
    logic              busy;

    int errors = 0;
    int checks = 0;

    imem_rw #(
        .ADDR_W        (c_AW),
        .DEPTH_LOG2    (4),
        .DATA_W        (32),
        .NOP           (c_NOP),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_en  (fetch_en),
        .addr      (addr),
        .inst      (inst),
        .inst_valid(inst_valid),
        .oor       (oor),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .wr_ready  (wr_ready),
        .wr_err    (wr_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a countdown of remaining sweep cycles, a word array,
    // and the last captured fetch address.
    logic [31:0]     m_mem [16];
    int              m_left;
    logic [c_AW-1:0] m_addr;
    logic            m_valid;
    logic            m_err;

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= 16;
            m_addr  <= '0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
        end else if (m_left > 0) begin
            m_mem[4'(16 - m_left)] <= c_NOP;
            m_left <= m_left - 1;
            m_err  <= 1'b0;
        end else begin
            if (fetch_en) begin
                m_addr  <= addr;
                m_valid <= 1'b1;
            end
            m_err <= wr_en && (wr_addr >= c_AW'(16));
            if (wr_en && wr_addr < c_AW'(16)) begin
                m_mem[wr_addr[3:0]] <= merge(m_mem[wr_addr[3:0]], wr_data, wr_be);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [31:0] e_inst;
        logic        e_oor;
        e_oor  = m_valid && (m_addr >= c_AW'(16));
        e_inst = (m_valid && !e_oor) ? m_mem[m_addr[3:0]] : c_NOP;
        chk("inst",       inst,               e_inst);
        chk("inst_valid", 32'(inst_valid),    32'(m_valid));
        chk("oor",        32'(oor),           32'(e_oor));
        chk("wr_err",     32'(wr_err),        32'(m_err));
        chk("busy",       32'(busy),          32'(m_left != 0));
        chk("wr_ready",   32'(wr_ready),      32'(m_left == 0));
    endtask

    // One cycle: the edge samples the current inputs, outputs are compared
    // against the model on the following falling edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        fetch_en = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic fetch(input logic [c_AW-1:0] a);
        fetch_en = 1'b1;
        addr     = a;
        wr_en    = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [c_AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        fetch_en = 1'b0;
        wr_en    = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_be    = be;
        tick();
        wr_en    = 1'b0;
    endtask

    task automatic count_sweep(input bit poke_writes);
        int n;
        n = 0;
        do begin
            if (poke_writes) begin
                wr_en   = 1'b1;
                wr_addr = ($urandom_range(0, 3) == 0) ? c_AW'($urandom) : c_AW'($urandom_range(0, 15));
                wr_data = $urandom;
                wr_be   = 4'hF;
                fetch_en = 1'b1;
                addr    = c_AW'($urandom_range(0, 15));
            end
            tick();
            n++;
        end while (busy && n < 100);
        idle();
        chk("busy_cycles", 32'(n), 32'd16);
    endtask

    initial begin
        #2 rst = 1'b1;
        tick();
        chk("rst_busy",     32'(busy),       32'd1);
        chk("rst_wr_ready", 32'(wr_ready),   32'd0);
        chk("rst_inst",     inst,            32'h0);
        chk("rst_valid",    32'(inst_valid), 32'd0);
        tick();
        rst = 1'b0;
        count_sweep(1'b0);

        for (int i = 0; i < 16; i++) begin
            fetch(c_AW'(i));
            chk("clr_fetch", inst, 32'h0000_0000);
            chk("clr_valid", 32'(inst_valid), 32'd1);
        end

        wr(30'd0, 32'h3c1d1000, 4'hF);
        wr(30'd1, 32'h0c000343, 4'hF);
        wr(30'd2, 32'h11223344, 4'hF);
        wr(30'd2, 32'hAABBCCDD, 4'b0101);
        wr(30'd2, 32'h55555555, 4'b0000);
        fetch(30'd0);
        chk("load0", inst, 32'h3c1d1000);
        fetch(30'd1);
        chk("load1", inst, 32'h0c000343);
        fetch(30'd2);
        chk("byte_en", inst, 32'h11BB33DD);
        chk("model_byte_en", m_mem[2], 32'h11BB33DD);

        wr(30'd3, 32'h12345678, 4'hF);
        fetch(30'd3);
        chk("cap3", inst, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            fetch_en = 1'b0;
            addr     = c_AW'($urandom_range(0, 15));
            tick();
            chk("stall", inst, 32'h12345678);
        end
        wr(30'd3, 32'hDEADBEEF, 4'hF);
        chk("collide", inst, 32'hDEADBEEF);

        fetch_en = 1'b1;
        addr     = 30'd4;
        wr_en    = 1'b1;
        wr_addr  = 30'd4;
        wr_data  = 32'hCAFEF00D;
        wr_be    = 4'hF;
        tick();
        idle();
        chk("wr_and_fetch", inst, 32'hCAFEF00D);

        fetch(30'h00000010);
        chk("oor_inst", inst, c_NOP);
        chk("oor_flag", 32'(oor), 32'd1);
        fetch(30'h20000000);
        chk("oor_high", 32'(oor), 32'd1);
        wr(30'h3FFFFFFF, 32'hFFFFFFFF, 4'hF);
        chk("wr_err_on", 32'(wr_err), 32'd1);
        tick();
        chk("wr_err_off", 32'(wr_err), 32'd0);
        fetch(30'd15);
        chk("addr15_kept", inst, 32'h0);

        for (int i = 0; i < 400; i++) begin
            fetch_en = ($urandom_range(0, 3) != 0);
            addr     = ($urandom_range(0, 9) == 0) ? c_AW'($urandom) : c_AW'($urandom_range(0, 19));
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = ($urandom_range(0, 9) == 0) ? c_AW'($urandom) : c_AW'($urandom_range(0, 19));
            wr_data  = $urandom;
            wr_be    = 4'($urandom_range(0, 15));
            tick();
        end
        idle();

        // Reset in the middle of the sweep must restart it from word 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        count_sweep(1'b1);
        for (int i = 0; i < 16; i++) begin
            fetch(c_AW'(i));
            chk("reclr_fetch", inst, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
